voice_allocator: RTL and testbench

- Sequences voice assignment for the polyphonic synth engine. Accepts decoded note commands (on / off / all-off) from the MIDI front end over a valid/ready handshake.
- Selects a voice using a free → oldest-released → oldest-held (steal) policy, and emits one-cycle assignment/release events plus a per-voice gate vector.
- Sits between the MIDI decoder and the voice/envelope array. It owns all voice-to-key bookkeeping.

---
 rtl/voice_alloc_pkg.sv | 9 +
 rtl/voice_alloc_pick.sv | 26 ++
 rtl/voice_allocator.sv | 198 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared encodings for the voice allocator: command opcodes, empty-slot marker, FSM states.
package voice_alloc_pkg;
   localparam logic [1:0] OP_NOTE_ON  = 2'd0;
   localparam logic [1:0] OP_NOTE_OFF = 2'd1;
   localparam logic [1:0] OP_ALL_OFF  = 2'd2;
   localparam logic [7:0] KEY_NONE    = 8'hFF;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
endpackage

// File: rtl/voice_alloc_pick.sv
// voice_pick: combinational selector returning the oldest masked voice, ties to the lowest index.
module voice_pick #(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = 3
) (
   input  logic [VOICES-1:0]              mask,
   input  logic [VOICES-1:0][V_WIDTH-1:0] ages,
   output logic [V_WIDTH-1:0]             idx,
   output logic                           found
);
   logic [V_WIDTH-1:0] best;

   // Strict greater-than keeps the first (lowest) index on equal ages.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      best  = '0;
      for (int i = 0; i < VOICES; i++) begin
         if (mask[i] && (!found || ages[i] > best)) begin
            idx   = V_WIDTH'(i);
            found = 1'b1;
            best  = ages[i];
         end
      end
   end
endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: free -> oldest-released -> oldest-held (steal) assignment with per-voice gates.
// Optional build macro VOICE_ALLOC_RETRIGGER_EN: NOTE_ON of an already gated key reuses that voice.
module voice_allocator
   import voice_alloc_pkg::*;
#(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = 3
) (
   input  logic               CLOCK_25,
   input  logic               iRST_N,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [6:0]         cmd_key,
   input  logic [6:0]         cmd_vel,
   input  logic [VOICES-1:0]  voice_free,
   output logic [VOICES-1:0]  keys_on,
   output logic               ev_on,
   output logic               ev_off,
   output logic [V_WIDTH-1:0] ev_voice,
   output logic [7:0]         ev_key,
   output logic [7:0]         ev_vel,
   output logic               ev_steal,
   output logic               off_miss,
   output logic [V_WIDTH:0]   active_keys
);
   state_t state_q, state_d;

   logic [1:0] op_p0;
   logic [6:0] key_p0, vel_p0;

   logic [VOICES-1:0][7:0]         slot;
   logic [VOICES-1:0][V_WIDTH-1:0] age;

   logic [V_WIDTH-1:0] free_idx, match_idx, rel_idx, old_idx;
   logic               free_found, match_found, rel_found, old_found;

   logic [V_WIDTH-1:0] free_idx_p1, match_idx_p1, rel_idx_p1, old_idx_p1;
   logic               free_found_p1, match_found_p1, rel_found_p1, old_found_p1;

   logic [V_WIDTH-1:0] tgt;
   logic               steal, retrig;

   function automatic logic [V_WIDTH-1:0] sat_inc(input logic [V_WIDTH-1:0] a);
      return (&a) ? a : a + 1'b1;
   endfunction

   always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
      if (!iRST_N) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && (cmd_op == OP_NOTE_ON || cmd_op == OP_NOTE_OFF))
               state_d = SCAN;
         end
         SCAN:    state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      free_idx    = '0;
      free_found  = 1'b0;
      match_idx   = '0;
      match_found = 1'b0;
      for (int i = 0; i < VOICES; i++) begin
         if (!free_found && voice_free[i] && !keys_on[i]) begin
            free_idx   = V_WIDTH'(i);
            free_found = 1'b1;
         end
         if (!match_found && keys_on[i] && slot[i] == {1'b0, key_p0}) begin
            match_idx   = V_WIDTH'(i);
            match_found = 1'b1;
         end
      end
   end

   voice_pick #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_pick_rel (
      .mask(~keys_on), .ages(age), .idx(rel_idx), .found(rel_found)
   );

   voice_pick #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_pick_old (
      .mask(keys_on), .ages(age), .idx(old_idx), .found(old_found)
   );

   always_comb begin
      tgt    = '0;
      steal  = 1'b0;
      retrig = 1'b0;
      if (free_found_p1)     tgt = free_idx_p1;
      else if (rel_found_p1) tgt = rel_idx_p1;
      else if (old_found_p1) begin
         tgt   = old_idx_p1;
         steal = 1'b1;
      end
`ifdef VOICE_ALLOC_RETRIGGER_EN
      if (match_found_p1) begin
         tgt    = match_idx_p1;
         steal  = 1'b0;
         retrig = 1'b1;
      end
`endif
   end

   always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
      if (!iRST_N) begin
         op_p0          <= '0;
         key_p0         <= '0;
         vel_p0         <= '0;
         keys_on        <= '0;
         slot           <= {VOICES{KEY_NONE}};
         age            <= '0;
         active_keys    <= '0;
         free_idx_p1    <= '0;
         match_idx_p1   <= '0;
         rel_idx_p1     <= '0;
         old_idx_p1     <= '0;
         free_found_p1  <= 1'b0;
         match_found_p1 <= 1'b0;
         rel_found_p1   <= 1'b0;
         old_found_p1   <= 1'b0;
         ev_on          <= 1'b0;
         ev_off         <= 1'b0;
         ev_steal       <= 1'b0;
         off_miss       <= 1'b0;
         ev_voice       <= '0;
         ev_key         <= KEY_NONE;
         ev_vel         <= '0;
      end else begin
         ev_on    <= 1'b0;
         ev_off   <= 1'b0;
         ev_steal <= 1'b0;
         off_miss <= 1'b0;
         ev_voice <= '0;
         ev_key   <= KEY_NONE;
         ev_vel   <= '0;
         case (state_q)
            // p0: latch the command; ALL_OFF finishes here
            IDLE: begin
               if (cmd_valid) begin
                  op_p0  <= cmd_op;
                  key_p0 <= cmd_key;
                  vel_p0 <= cmd_vel;
                  if (cmd_op == OP_ALL_OFF) begin
                     keys_on     <= '0;
                     slot        <= {VOICES{KEY_NONE}};
                     active_keys <= '0;
                  end
               end
            end
            // p1: register search results; voice_free is only looked at here
            SCAN: begin
               free_idx_p1    <= free_idx;
               free_found_p1  <= free_found;
               match_idx_p1   <= match_idx;
               match_found_p1 <= match_found;
               rel_idx_p1     <= rel_idx;
               rel_found_p1   <= rel_found;
               old_idx_p1     <= old_idx;
               old_found_p1   <= old_found;
            end
            // p2: apply the allocation and emit events
            COMMIT: begin
               if (op_p0 == OP_NOTE_ON) begin
                  for (int i = 0; i < VOICES; i++) begin
                     if (V_WIDTH'(i) == tgt) age[i] <= '0;
                     else if (keys_on[i])    age[i] <= sat_inc(age[i]);
                  end
                  keys_on[tgt] <= 1'b1;
                  slot[tgt]    <= {1'b0, key_p0};
                  if (!steal && !retrig) active_keys <= active_keys + 1'b1;
                  ev_on    <= 1'b1;
                  ev_steal <= steal;
                  ev_voice <= tgt;
                  ev_key   <= {1'b0, key_p0};
                  ev_vel   <= {1'b0, vel_p0};
               end else if (match_found_p1) begin
                  keys_on[match_idx_p1] <= 1'b0;
                  slot[match_idx_p1]    <= KEY_NONE;
                  active_keys           <= active_keys - 1'b1;
                  ev_off                <= 1'b1;
                  ev_voice              <= match_idx_p1;
               end else begin
                  off_miss <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random commands against a behavioural model.
module tb_voice_allocator;
   import voice_alloc_pkg::*;
   localparam int VOICES = 8;

   logic       CLOCK_25 = 1'b0;
   logic       iRST_N = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = '0;
   logic [6:0] cmd_key = '0, cmd_vel = '0;
   logic [7:0] voice_free = '0;
   logic [7:0] keys_on;
   logic       ev_on, ev_off, ev_steal, off_miss;
   logic [2:0] ev_voice;
   logic [7:0] ev_key, ev_vel;
   logic [3:0] active_keys;

   int errors = 0;
   int checks = 0;

   bit m_gate[VOICES];
   int m_slot[VOICES];
   int m_age[VOICES];

   logic       e_on, e_off, e_steal, e_miss;
   logic [2:0] e_voice;
   logic [7:0] e_key, e_vel, e_keys;
   logic [3:0] e_active;

   logic       o_ready_mid, o_on, o_off, o_steal, o_miss;
   logic [2:0] o_voice;
   logic [7:0] o_key, o_vel, o_keys;
   logic [3:0] o_active;

   voice_allocator #(.VOICES(8), .V_WIDTH(3)) dut (
      .CLOCK_25(CLOCK_25), .iRST_N(iRST_N),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_vel(cmd_vel),
      .voice_free(voice_free), .keys_on(keys_on),
      .ev_on(ev_on), .ev_off(ev_off), .ev_voice(ev_voice),
      .ev_key(ev_key), .ev_vel(ev_vel), .ev_steal(ev_steal),
      .off_miss(off_miss), .active_keys(active_keys)
   );

   always #20 CLOCK_25 = ~CLOCK_25;

   task automatic model_reset();
      for (int v = 0; v < VOICES; v++) begin
         m_gate[v] = 0; m_slot[v] = 255; m_age[v] = 0;
      end
   endtask

   task automatic model_step(input logic [1:0] op, input logic [6:0] key, input logic [6:0] vel,
                             input logic [7:0] vf);
      int t, f, r, o, m, cnt;
      e_on = 0; e_off = 0; e_steal = 0; e_miss = 0; e_voice = 0; e_key = 8'hFF; e_vel = 0;
      m = -1; f = -1; r = -1; o = -1; t = 0;
      for (int v = 0; v < VOICES; v++) begin
         if (m < 0 && m_gate[v] && m_slot[v] == int'(key)) m = v;
         if (f < 0 && vf[v] && !m_gate[v]) f = v;
         if (!m_gate[v] && (r < 0 || m_age[v] > m_age[r])) r = v;
         if (m_gate[v] && (o < 0 || m_age[v] > m_age[o])) o = v;
      end
      if (op == OP_NOTE_ON) begin
`ifdef VOICE_ALLOC_RETRIGGER_EN
         if (m >= 0) t = m; else
`endif
         if (f >= 0) t = f;
         else if (r >= 0) t = r;
         else begin t = o; e_steal = 1; end
         for (int v = 0; v < VOICES; v++)
            if (v != t && m_gate[v]) m_age[v] = (m_age[v] >= 7) ? 7 : m_age[v] + 1;
         m_age[t] = 0; m_gate[t] = 1; m_slot[t] = key;
         e_on = 1; e_voice = 3'(t); e_key = {1'b0, key}; e_vel = {1'b0, vel};
      end else if (op == OP_NOTE_OFF) begin
         if (m >= 0) begin
            m_gate[m] = 0; m_slot[m] = 255;
            e_off = 1; e_voice = 3'(m);
         end else e_miss = 1;
      end else if (op == OP_ALL_OFF) begin
         for (int v = 0; v < VOICES; v++) begin m_gate[v] = 0; m_slot[v] = 255; end
      end
      cnt = 0;
      for (int v = 0; v < VOICES; v++) begin
         e_keys[v] = m_gate[v];
         cnt += int'(m_gate[v]);
      end
      e_active = 4'(cnt);
   endtask

   task automatic issue(input logic [1:0] op, input logic [6:0] key, input logic [6:0] vel,
                        input logic [7:0] vf);
      int w;
      w = 0;
      while (!cmd_ready && w < 8) begin @(negedge CLOCK_25); w++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_op = op; cmd_key = key; cmd_vel = vel; voice_free = vf; cmd_valid = 1'b1;
      @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      cmd_valid = 1'b0;
      o_ready_mid = cmd_ready;
      if (op == OP_NOTE_ON || op == OP_NOTE_OFF) begin
         @(negedge CLOCK_25);
         @(negedge CLOCK_25);
      end
      o_on = ev_on; o_off = ev_off; o_steal = ev_steal; o_miss = off_miss;
      o_voice = ev_voice; o_key = ev_key; o_vel = ev_vel; o_keys = keys_on; o_active = active_keys;
   endtask

   task automatic run(input logic [1:0] op, input logic [6:0] key, input logic [6:0] vel,
                      input logic [7:0] vf);
      model_step(op, key, vel, vf);
      issue(op, key, vel, vf);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({keys_on, active_keys, ev_on, ev_off, off_miss, ev_key, cmd_ready} !== {8'h00, 4'd0, 3'b000, 8'hFF, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: keys=%h act=%0d on/off/miss=%b%b%b key=%h rdy=%b required 00 0 000 ff 1",
                  keys_on, active_keys, ev_on, ev_off, off_miss, ev_key, cmd_ready);
      end
      @(negedge CLOCK_25); iRST_N = 1'b1;
      model_reset();
   endtask

   task automatic test_first_note();
      run(OP_NOTE_ON, 7'd60, 7'd100, 8'hFF);
      checks++;
      if (o_ready_mid !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b required 0", o_ready_mid); end
      checks++;
      if ({o_on, o_steal, o_voice, o_key, o_vel, o_keys, o_active} !== {1'b1, 1'b0, 3'd0, 8'd60, 8'd100, 8'h01, 4'd1}) begin
         errors++;
         $display("FAIL first_note: on=%b st=%b v=%0d key=%0d vel=%0d keys=%h act=%0d required 1 0 0 60 100 01 1",
                  o_on, o_steal, o_voice, o_key, o_vel, o_keys, o_active);
      end
   endtask

   task automatic test_fill_and_steal();
      for (int k = 61; k <= 67; k++) begin
         run(OP_NOTE_ON, 7'(k), 7'd90, 8'hFF);
         checks++;
         if (o_voice !== 3'(k - 60) || o_on !== 1'b1) begin
            errors++; $display("FAIL fill_voice key %0d: voice=%0d on=%b required %0d 1", k, o_voice, o_on, k - 60);
         end
      end
      run(OP_NOTE_ON, 7'd70, 7'd33, 8'h00);
      checks++;
      if ({o_on, o_steal, o_voice, o_keys, o_active} !== {1'b1, 1'b1, 3'd0, 8'hFF, 4'd8}) begin
         errors++;
         $display("FAIL steal: on=%b st=%b v=%0d keys=%h act=%0d required 1 1 0 ff 8",
                  o_on, o_steal, o_voice, o_keys, o_active);
      end
   endtask

   task automatic test_off_and_rel();
      run(OP_NOTE_OFF, 7'd62, 7'd0, 8'h00);
      checks++;
      if ({o_off, o_on, o_voice, o_key, o_keys, o_active} !== {1'b1, 1'b0, 3'd2, 8'hFF, 8'hFB, 4'd7}) begin
         errors++;
         $display("FAIL note_off: off=%b on=%b v=%0d key=%h keys=%h act=%0d required 1 0 2 ff fb 7",
                  o_off, o_on, o_voice, o_key, o_keys, o_active);
      end
      run(OP_NOTE_ON, 7'd80, 7'd64, 8'h00);
      checks++;
      if ({o_on, o_steal, o_voice, o_active} !== {1'b1, 1'b0, 3'd2, 4'd8}) begin
         errors++;
         $display("FAIL reuse_released: on=%b st=%b v=%0d act=%0d required 1 0 2 8", o_on, o_steal, o_voice, o_active);
      end
   endtask

   task automatic test_off_miss();
      run(OP_NOTE_OFF, 7'd99, 7'd0, 8'h00);
      checks++;
      if ({o_miss, o_off, o_on, o_keys, o_active} !== {1'b1, 1'b0, 1'b0, 8'hFF, 4'd8}) begin
         errors++;
         $display("FAIL off_miss: miss=%b off=%b on=%b keys=%h act=%0d required 1 0 0 ff 8",
                  o_miss, o_off, o_on, o_keys, o_active);
      end
   endtask

   task automatic test_all_off();
      run(OP_ALL_OFF, 7'd0, 7'd0, 8'h00);
      for (int k = 0; k < 5; k++) run(OP_NOTE_ON, 7'(40 + k), 7'd50, 8'hFF);
      checks++;
      if (o_keys !== 8'h1F) begin errors++; $display("FAIL five_gated: keys=%h required 1f", o_keys); end
      run(OP_ALL_OFF, 7'd0, 7'd0, 8'h00);
      checks++;
      if ({o_keys, o_active, o_ready_mid, o_off} !== {8'h00, 4'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL all_off: keys=%h act=%0d rdy=%b off=%b required 00 0 1 0", o_keys, o_active, o_ready_mid, o_off);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      run(OP_NOTE_ON, 7'd50, 7'd10, 8'hFF);
      cmd_op = OP_NOTE_ON; cmd_key = 7'd51; cmd_vel = 7'd20; voice_free = 8'hFF; cmd_valid = 1'b1;
      @(posedge CLOCK_25);
      @(negedge CLOCK_25);
      cmd_valid = 1'b0;
      iRST_N = 1'b0;
      #1;
      checks++;
      if ({keys_on, active_keys, ev_on, ev_key, cmd_ready} !== {8'h00, 4'd0, 1'b0, 8'hFF, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid: keys=%h act=%0d on=%b key=%h rdy=%b required 00 0 0 ff 1",
                  keys_on, active_keys, ev_on, ev_key, cmd_ready);
      end
      @(negedge CLOCK_25); iRST_N = 1'b1;
      model_reset();
      pulses = 0;
      for (int c = 0; c < 4; c++) begin @(negedge CLOCK_25); pulses += int'(ev_on); end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL aborted_cmd: ev_on pulses=%0d required 0", pulses); end
   endtask

   task automatic test_duplicate_key();
      run(OP_NOTE_ON, 7'd60, 7'd70, 8'hFF);
      run(OP_NOTE_ON, 7'd60, 7'd71, 8'hFF);
      checks++;
`ifdef VOICE_ALLOC_RETRIGGER_EN
      if ({o_voice, o_steal, o_active} !== {3'd0, 1'b0, 4'd1}) begin
         errors++; $display("FAIL retrigger: v=%0d st=%b act=%0d required 0 0 1", o_voice, o_steal, o_active);
      end
`else
      if ({o_voice, o_steal, o_active} !== {3'd1, 1'b0, 4'd2}) begin
         errors++; $display("FAIL dup_key: v=%0d st=%b act=%0d required 1 0 2", o_voice, o_steal, o_active);
      end
`endif
      run(OP_NOTE_OFF, 7'd60, 7'd0, 8'h00);
      checks++;
      if ({o_off, o_voice} !== {1'b1, 3'd0}) begin
         errors++; $display("FAIL dup_release: off=%b v=%0d required 1 0", o_off, o_voice);
      end
   endtask

   task automatic test_random();
      logic [1:0] op;
      int r;
      for (int n = 0; n < 120; n++) begin
         r = $urandom_range(0, 99);
         op = (r < 45) ? OP_NOTE_ON : (r < 80) ? OP_NOTE_OFF : (r < 90) ? OP_ALL_OFF : 2'd3;
         run(op, 7'(60 + $urandom_range(0, 9)), 7'($urandom), 8'($urandom));
         checks++;
         if ({o_on, o_off, o_steal, o_miss, o_key, o_vel} !== {e_on, e_off, e_steal, e_miss, e_key, e_vel}) begin
            errors++;
            $display("FAIL rnd%0d events: on/off/st/miss=%b%b%b%b key=%h vel=%h required %b%b%b%b %h %h", n,
                     o_on, o_off, o_steal, o_miss, o_key, o_vel, e_on, e_off, e_steal, e_miss, e_key, e_vel);
         end
         if (e_on || e_off) begin
            checks++;
            if (o_voice !== e_voice) begin
               errors++; $display("FAIL rnd%0d voice: got %0d required %0d", n, o_voice, e_voice);
            end
         end
         checks++;
         if ({o_keys, o_active} !== {e_keys, e_active}) begin
            errors++;
            $display("FAIL rnd%0d state: keys=%h act=%0d required %h %0d", n, o_keys, o_active, e_keys, e_active);
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge CLOCK_25);
      test_reset();
      test_first_note();
      test_fill_and_steal();
      test_off_and_rel();
      test_off_miss();
      test_all_off();
      test_reset_mid();
      test_duplicate_key();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
